// File: rtl/temp_sensor_multi_reader.sv
// Multi-channel SPI poller for MAX6630-class temperature sensors.
// Optional high-temperature alarm enabled by TEMP_SENSOR_ALARM_EN.
module temp_sensor_multi_reader #(
    parameter int C_CHANNELS            = 4,
    parameter int C_TEMP_SENSOR_PO_WL   = 16,
    parameter int C_TEMP_SENSOR_DATA_WL = 13,
    parameter int C_SCK_DIV             = 8,
    parameter int C_SWEEP_GAP           = 1000
) (
    input  logic                    Clk_IN,
    input  logic                    Rst_IN,
    input  logic                    Start_IN,
    input  logic                    Auto_IN,
    input  logic [C_CHANNELS-1:0]   Chan_En_IN,
    input  logic                    Temp_sensor_SO_IN,
    output logic                    Temp_sensor_SCK_OUT,
    output logic [C_CHANNELS-1:0]   Temp_sensor_CS_OUT,
    output logic [C_CHANNELS*C_TEMP_SENSOR_DATA_WL-1:0] Temp_Data_OUT,
    output logic [C_CHANNELS-1:0]   Data_Valid_OUT,
    output logic [C_CHANNELS-1:0]   Frame_Error_OUT,
    output logic                    Busy_OUT,
    output logic                    Sweep_Done_OUT
`ifdef TEMP_SENSOR_ALARM_EN
    ,
    input  logic signed [C_TEMP_SENSOR_DATA_WL-1:0] Temp_High_Thr_IN,
    output logic [C_CHANNELS-1:0]   Alarm_OUT
`endif
);

    localparam int PW  = C_TEMP_SENSOR_PO_WL;
    localparam int DW  = C_TEMP_SENSOR_DATA_WL;
    localparam int CHK = PW - DW - 1;
    localparam int CW  = (C_CHANNELS > 1) ? $clog2(C_CHANNELS) : 1;
    localparam int KW  = $clog2(C_SCK_DIV);
    localparam int BW  = $clog2(PW);
    localparam int GW  = (C_SWEEP_GAP > 1) ? $clog2(C_SWEEP_GAP) : 1;

    typedef enum logic [2:0] {
        IDLE, CS_SETUP, SCK_HIGH, SCK_LOW, CS_GAP, NEXT, DONE, WAIT_GAP
    } state_t;

    state_t                state;
    logic [CW-1:0]         ch;
    logic [CW-1:0]         nxt;
    logic                  found;
    logic [C_CHANNELS-1:0] rem;
    logic [KW-1:0]         cnt;
    logic [BW-1:0]         bits;
    logic [GW-1:0]         gap;
    logic [PW-1:0]         sr;
    logic [1:0]            so_sync;
    logic [DW-1:0]         temp_q [C_CHANNELS];

    logic          cnt_end;
    logic          last_bit;
    logic          adv;
    logic          frame_ok;
    logic [DW-1:0] field;

    assign cnt_end  = (cnt == KW'(C_SCK_DIV - 1));
    assign last_bit = (bits == BW'(PW - 1));
    assign adv      = (state == NEXT) || (state == CS_GAP && cnt_end);
    assign field    = sr[PW-1 -: DW];
    // Reserved bit must read 0; an open bus shifts in all ones.
    assign frame_ok = ~sr[CHK];

    // Lowest-index channel still pending in this sweep.
    always_comb begin
        found = 1'b0;
        nxt   = '0;
        for (int i = C_CHANNELS - 1; i >= 0; i--) begin
            if (rem[i]) begin
                found = 1'b1;
                nxt   = CW'(i);
            end
        end
    end

    for (genvar g = 0; g < C_CHANNELS; g++) begin : g_data
        assign Temp_Data_OUT[g*DW +: DW] = temp_q[g];
    end

    always_ff @(posedge Clk_IN) begin
        if (Rst_IN) begin
            state               <= IDLE;
            ch                  <= '0;
            rem                 <= '0;
            cnt                 <= '0;
            bits                <= '0;
            gap                 <= '0;
            sr                  <= '0;
            so_sync             <= '0;
            Temp_sensor_SCK_OUT <= 1'b0;
            Temp_sensor_CS_OUT  <= '1;
            Data_Valid_OUT      <= '0;
            Frame_Error_OUT     <= '0;
            Busy_OUT            <= 1'b0;
            Sweep_Done_OUT      <= 1'b0;
            for (int i = 0; i < C_CHANNELS; i++) temp_q[i] <= '0;
`ifdef TEMP_SENSOR_ALARM_EN
            Alarm_OUT           <= '0;
`endif
        end else begin
            so_sync        <= {so_sync[0], Temp_sensor_SO_IN};
            Sweep_Done_OUT <= 1'b0;
            if (state inside {CS_SETUP, SCK_HIGH, SCK_LOW, CS_GAP})
                cnt <= cnt_end ? '0 : cnt + 1'b1;

            unique case (state)
                IDLE: begin
                    if (Start_IN) begin
                        rem      <= Chan_En_IN;
                        Busy_OUT <= 1'b1;
                        state    <= NEXT;
                    end
                end
                CS_SETUP: begin
                    if (cnt_end) begin
                        Temp_sensor_SCK_OUT <= 1'b1;
                        sr    <= {sr[PW-2:0], so_sync[1]};
                        bits  <= '0;
                        state <= SCK_HIGH;
                    end
                end
                SCK_HIGH: begin
                    if (cnt_end) begin
                        Temp_sensor_SCK_OUT <= 1'b0;
                        state <= SCK_LOW;
                    end
                end
                SCK_LOW: begin
                    if (cnt_end && last_bit) begin
                        Temp_sensor_CS_OUT  <= '1;
                        Data_Valid_OUT[ch]  <= frame_ok;
                        Frame_Error_OUT[ch] <= ~frame_ok;
                        if (frame_ok) temp_q[ch] <= field;
`ifdef TEMP_SENSOR_ALARM_EN
                        Alarm_OUT[ch] <= frame_ok &&
                            ($signed(field) > Temp_High_Thr_IN);
`endif
                        state <= CS_GAP;
                    end else if (cnt_end) begin
                        Temp_sensor_SCK_OUT <= 1'b1;
                        sr    <= {sr[PW-2:0], so_sync[1]};
                        bits  <= bits + 1'b1;
                        state <= SCK_HIGH;
                    end
                end
                CS_GAP, NEXT: ;
                DONE: begin
                    gap   <= '0;
                    state <= Auto_IN ? WAIT_GAP : IDLE;
                end
                WAIT_GAP: begin
                    if (!Auto_IN) begin
                        state <= IDLE;
                    end else if (gap == GW'(C_SWEEP_GAP - 1)) begin
                        rem      <= Chan_En_IN;
                        Busy_OUT <= 1'b1;
                        state    <= NEXT;
                    end else begin
                        gap <= gap + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase

            // The gap of one channel flows straight into the next CS setup.
            if (adv) begin
                if (found) begin
                    Temp_sensor_CS_OUT <= ~(C_CHANNELS'(1) << nxt);
                    ch       <= nxt;
                    rem[nxt] <= 1'b0;
                    cnt      <= '0;
                    state    <= CS_SETUP;
                end else begin
                    Busy_OUT       <= 1'b0;
                    Sweep_Done_OUT <= 1'b1;
                    state          <= DONE;
                end
            end
        end
    end

endmodule

// File: tb/tb_temp_sensor_multi_reader.sv
// Bench for temp_sensor_multi_reader: sweep vector table with a
// result scoreboard, plus reset, auto-repeat and alarm sequences.
module tb_temp_sensor_multi_reader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        auto_m = 1'b0;
    logic [3:0]  chan_en = 4'h0;
    logic        so;
    logic        sck;
    logic [3:0]  cs;
    logic [51:0] temp;
    logic [3:0]  valid;
    logic [3:0]  err;
    logic        busy;
    logic        done;
`ifdef TEMP_SENSOR_ALARM_EN
    logic signed [12:0] thr = 13'sh0180;
    logic [3:0]  alarm;
`endif

    always #5 clk = ~clk;

    temp_sensor_multi_reader dut (
        .Clk_IN              (clk),
        .Rst_IN              (rst),
        .Start_IN            (start),
        .Auto_IN             (auto_m),
        .Chan_En_IN          (chan_en),
        .Temp_sensor_SO_IN   (so),
        .Temp_sensor_SCK_OUT (sck),
        .Temp_sensor_CS_OUT  (cs),
        .Temp_Data_OUT       (temp),
        .Data_Valid_OUT      (valid),
        .Frame_Error_OUT     (err),
        .Busy_OUT            (busy),
        .Sweep_Done_OUT      (done)
`ifdef TEMP_SENSOR_ALARM_EN
        ,
        .Temp_High_Thr_IN    (thr),
        .Alarm_OUT           (alarm)
`endif
    );

    // Sensor model: MSB presented at CS fall, next bit after each SCK fall.
    logic [63:0] frames = '0;
    int          bitidx = 15;
    logic        sck_q = 1'b0;

    always @(posedge clk) begin
        if (&cs) bitidx <= 15;
        else if (sck_q && !sck) bitidx <= bitidx - 1;
        sck_q <= sck;
    end

    always_comb begin
        so = 1'b1;
        for (int i = 0; i < 4; i++)
            if (cs[i] === 1'b0 && bitidx >= 0) so = frames[i*16 + bitidx];
    end

    // Bus monitor.
    int         rises = 0;
    int         multi_low = 0;
    logic       sck_p = 1'b0;
    logic [3:0] cs_p = 4'hF;
    int         obs_order[$];

    always @(negedge clk) begin
        if (sck === 1'b1 && sck_p === 1'b0) rises++;
        sck_p = sck;
        if ($countones(~cs) > 1) multi_low++;
        for (int i = 0; i < 4; i++)
            if (cs[i] === 1'b0 && cs_p[i] === 1'b1) obs_order.push_back(i);
        cs_p = cs;
    end

    typedef struct {
        logic [3:0]  mask;
        logic [63:0] frames;
        logic [51:0] t;
        logic [3:0]  v;
        logic [3:0]  e;
    } vec_t;

    typedef struct {
        int          ch;
        logic [12:0] t;
        logic        v;
        logic        e;
    } exp_t;

    vec_t vecs[6];
    exp_t sbq[$];
    int   n_pass = 0;
    int   n_total = 0;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic run_vec(input vec_t v);
        int   n;
        int   k;
        int   r0;
        int   m0;
        int   eo[$];
        exp_t e;
        frames = v.frames;
        k = $countones(v.mask);
        for (int c = 0; c < 4; c++) begin
            sbq.push_back('{c, v.t[c*13 +: 13], v.v[c], v.e[c]});
            if (v.mask[c]) eo.push_back(c);
        end
        obs_order.delete();
        r0 = rises;
        m0 = multi_low;
        @(negedge clk);
        start = 1'b1;
        chan_en = v.mask;
        n = 0;
        do begin
            @(negedge clk);
            start = 1'b0;
            chan_en = 4'h0;
            n++;
            if (n == 1) chk("busy_in_sweep", busy, 1);
        end while (done !== 1'b1 && n < 1200);
        chk("done_latency", n, 2 + 272 * k);
        chk("busy_at_done", busy, 0);
        @(negedge clk);
        chk("done_one_cycle", done, 0);
        chk("sck_rises", rises - r0, 16 * k);
        chk("cs_one_low", multi_low - m0, 0);
        chk("cs_order_len", obs_order.size(), eo.size());
        for (int i = 0; i < eo.size() && i < obs_order.size(); i++)
            chk("cs_order", obs_order[i], eo[i]);
        while (sbq.size() > 0) begin
            e = sbq.pop_front();
            chk("temp_data", temp[e.ch*13 +: 13], e.t);
            chk("data_valid", valid[e.ch], e.v);
            chk("frame_error", err[e.ch], e.e);
        end
    endtask

    initial begin
        vec_t fresh;
        int   n;
        int   r0;
        int   seen;

        vecs[0] = '{4'b0001, 64'h0000_0000_0000_0C80,
                    {13'h0, 13'h0, 13'h0, 13'h190}, 4'b0001, 4'b0000};
        vecs[1] = '{4'b1010, 64'h0C80_0000_FB00_0000,
                    {13'h190, 13'h0, 13'h1F60, 13'h190}, 4'b1011, 4'b0000};
        vecs[2] = '{4'b0100, 64'h0000_0320_0000_0000,
                    {13'h190, 13'h064, 13'h1F60, 13'h190}, 4'b1111, 4'b0000};
        vecs[3] = '{4'b0100, 64'h0000_FFFF_0000_0000,
                    {13'h190, 13'h064, 13'h1F60, 13'h190}, 4'b1011, 4'b0100};
        vecs[4] = '{4'b0000, 64'h0,
                    {13'h190, 13'h064, 13'h1F60, 13'h190}, 4'b1011, 4'b0100};
        vecs[5] = '{4'b1111, 64'hFFF8_8000_7FF8_0004,
                    {13'h1FFF, 13'h1000, 13'h0FFF, 13'h190}, 4'b1110, 4'b0001};
        fresh   = '{4'b0001, 64'h0000_0000_0000_0C80,
                    {13'h0, 13'h0, 13'h0, 13'h190}, 4'b0001, 4'b0000};

        repeat (3) @(negedge clk);
        chk("rst_cs", cs, 4'hF);
        chk("rst_sck", sck, 0);
        chk("rst_temp", temp, 0);
        chk("rst_valid", valid, 0);
        chk("rst_err", err, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 6; i++) begin
            run_vec(vecs[i]);
`ifdef TEMP_SENSOR_ALARM_EN
            if (i == 1) chk("alarm", alarm, 4'b1001);
`endif
        end

        // Reset in the middle of a frame.
        frames = 64'h0000_0000_0000_0C80;
        @(negedge clk);
        start = 1'b1;
        chan_en = 4'b0001;
        @(negedge clk);
        start = 1'b0;
        chan_en = 4'h0;
        r0 = rises;
        n = 0;
        while (rises - r0 < 7 && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("reach_7th_rise", rises - r0, 7);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_cs", cs, 4'hF);
        chk("midrst_sck", sck, 0);
        chk("midrst_valid", valid, 0);
        chk("midrst_temp", temp, 0);
        chk("midrst_busy", busy, 0);
        repeat (3) @(negedge clk);
        run_vec(fresh);

        // Auto-repeat with ignored start pulses.
        frames = 64'h0000_0000_0000_0C80;
        auto_m = 1'b1;
        @(negedge clk);
        start = 1'b1;
        chan_en = 4'b0001;
        n = 0;
        do begin
            @(negedge clk);
            start = 1'b0;
            n++;
        end while (done !== 1'b1 && n < 400);
        chk("auto_first_done", done, 1);
        n = 0;
        do begin
            @(negedge clk);
            n++;
            if (n == 500) chk("busy_in_gap", busy, 0);
            if (n == 1100) chk("busy_in_auto", busy, 1);
            start = (n == 500 || n == 1100);
        end while (done !== 1'b1 && n < 1400);
        start = 1'b0;
        chk("auto_spacing", n, 1274);
        chk("auto_temp", temp[12:0], 13'h190);
        repeat (20) @(negedge clk);
        auto_m = 1'b0;
        seen = 0;
        repeat (1400) begin
            @(negedge clk);
            if (done === 1'b1) seen++;
        end
        chk("auto_off_no_done", seen, 0);
        chk("auto_off_idle", busy, 0);
        chk("auto_off_cs", cs, 4'hF);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
